// File: rtl/ras_commit_stack_if.sv
// rtl/ras_commit_stack_if.sv - commit-side and reload-side signal bundle for ras_commit_stack
//
// Purpose : groups the retire-stage inputs and the reload bus to the speculative RAS.
// Ports   : master drives CommitCall/CommitAddr/CommitRet/Flush and observes the reload bus;
//           slave (the stack) drives RELOAD, RELOADPTR, RELOADLINE1..15, STACKEMPTY, STACKFULL.
//           Each RELOADLINEn is packed {count, addr}.
interface ras_commit_stack_if #(
   parameter int STACKPTRW  = 4,
   parameter int STACKWIDE  = 32,
   parameter int RECURCOUNT = 7
);
   localparam int LW = STACKWIDE + RECURCOUNT;

   logic                 CommitCall;
   logic [STACKWIDE-1:0] CommitAddr;
   logic                 CommitRet;
   logic                 Flush;

   logic                 RELOAD;
   logic [STACKPTRW-1:0] RELOADPTR;
   logic [LW-1:0]        RELOADLINE1,  RELOADLINE2,  RELOADLINE3,  RELOADLINE4,  RELOADLINE5;
   logic [LW-1:0]        RELOADLINE6,  RELOADLINE7,  RELOADLINE8,  RELOADLINE9,  RELOADLINE10;
   logic [LW-1:0]        RELOADLINE11, RELOADLINE12, RELOADLINE13, RELOADLINE14, RELOADLINE15;
   logic                 STACKEMPTY;
   logic                 STACKFULL;

   modport master (
      output CommitCall, CommitAddr, CommitRet, Flush,
      input  RELOAD, RELOADPTR, STACKEMPTY, STACKFULL,
      input  RELOADLINE1,  RELOADLINE2,  RELOADLINE3,  RELOADLINE4,  RELOADLINE5,
      input  RELOADLINE6,  RELOADLINE7,  RELOADLINE8,  RELOADLINE9,  RELOADLINE10,
      input  RELOADLINE11, RELOADLINE12, RELOADLINE13, RELOADLINE14, RELOADLINE15
   );

   modport slave (
      input  CommitCall, CommitAddr, CommitRet, Flush,
      output RELOAD, RELOADPTR, STACKEMPTY, STACKFULL,
      output RELOADLINE1,  RELOADLINE2,  RELOADLINE3,  RELOADLINE4,  RELOADLINE5,
      output RELOADLINE6,  RELOADLINE7,  RELOADLINE8,  RELOADLINE9,  RELOADLINE10,
      output RELOADLINE11, RELOADLINE12, RELOADLINE13, RELOADLINE14, RELOADLINE15
   );
endinterface

// File: rtl/ras_commit_stack.sv
// rtl/ras_commit_stack.sv - committed (architectural) return-address stack with flush reload
//
// Purpose : tracks retiring calls/returns and holds the non-speculative RAS image; a flush
//           strobes RELOAD so the fetch-stage RAS reloads from this image.
// Ports   : Clk  - system clock
//           Rest - asynchronous active-high reset
//           bus  - slave side of ras_commit_stack_if (commit inputs, reload bus, status)
module ras_commit_stack #(
   parameter int STACKDEEP  = 16,
   parameter int STACKPTRW  = 4,
   parameter int STACKWIDE  = 32,
   parameter int RECURCOUNT = 7
) (
   input logic                Clk,
   input logic                Rest,
   ras_commit_stack_if.slave  bus
);
   // One storage slot is sacrificed: the reload bus only carries STACKDEEP-1 lines.
   localparam int USABLE = STACKDEEP - 1;

   localparam logic [STACKPTRW-1:0]  PTR_ONE = STACKPTRW'(1);
   localparam logic [STACKPTRW-1:0]  PTR_MAX = STACKPTRW'(USABLE);
   localparam logic [RECURCOUNT-1:0] CNT_ONE = RECURCOUNT'(1);
   localparam logic [RECURCOUNT-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic [RECURCOUNT-1:0] cnt;
      logic [STACKWIDE-1:0]  addr;
   } entry_t;

   entry_t [USABLE-1:0]  e, n_e;
   logic [STACKPTRW-1:0] ptr, n_ptr;
   logic [STACKPTRW-1:0] pop_idx, push_idx;
   logic                 reload;

   // Pop is resolved first; the push then sees the post-pop image so a
   // simultaneous return+call behaves like the return retired first.
   always_comb begin
      n_e      = e;
      n_ptr    = ptr;
      pop_idx  = ptr - PTR_ONE;
      push_idx = '0;

      if (bus.CommitRet && ptr != '0) begin
         if (n_e[pop_idx].cnt > CNT_ONE) begin
            n_e[pop_idx].cnt = n_e[pop_idx].cnt - CNT_ONE;
         end else begin
            n_e[pop_idx] = '0;
            n_ptr        = pop_idx;
         end
      end

      if (bus.CommitCall) begin
         push_idx = n_ptr - PTR_ONE;
         if (n_ptr != '0 && n_e[push_idx].addr == bus.CommitAddr &&
             n_e[push_idx].cnt != CNT_MAX) begin
            // Recursive call to the same return site: fold into the counter.
            n_e[push_idx].cnt = n_e[push_idx].cnt + CNT_ONE;
         end else if (n_ptr != PTR_MAX) begin
            n_e[n_ptr] = '{cnt: CNT_ONE, addr: bus.CommitAddr};
            n_ptr      = n_ptr + PTR_ONE;
         end else begin
            // Full: drop the oldest entry so the most recent calls survive.
            for (int i = 0; i < USABLE - 1; i++) begin
               n_e[i] = n_e[i+1];
            end
            n_e[USABLE-1] = '{cnt: CNT_ONE, addr: bus.CommitAddr};
         end
      end
   end

   always_ff @(posedge Clk or posedge Rest) begin
      if (Rest) begin
         ptr    <= '0;
         e      <= '0;
         reload <= 1'b0;
      end else begin
         ptr    <= n_ptr;
         e      <= n_e;
         reload <= bus.Flush;
      end
   end

   assign bus.RELOAD       = reload;
   assign bus.RELOADPTR    = ptr;
   assign bus.STACKEMPTY   = (ptr == '0);
   assign bus.STACKFULL    = (ptr == PTR_MAX);

   assign bus.RELOADLINE1  = e[0];
   assign bus.RELOADLINE2  = e[1];
   assign bus.RELOADLINE3  = e[2];
   assign bus.RELOADLINE4  = e[3];
   assign bus.RELOADLINE5  = e[4];
   assign bus.RELOADLINE6  = e[5];
   assign bus.RELOADLINE7  = e[6];
   assign bus.RELOADLINE8  = e[7];
   assign bus.RELOADLINE9  = e[8];
   assign bus.RELOADLINE10 = e[9];
   assign bus.RELOADLINE11 = e[10];
   assign bus.RELOADLINE12 = e[11];
   assign bus.RELOADLINE13 = e[12];
   assign bus.RELOADLINE14 = e[13];
   assign bus.RELOADLINE15 = e[14];
endmodule

// File: tb/tb_ras_commit_stack.sv
// tb/tb_ras_commit_stack.sv - self-checking bench for ras_commit_stack
module tb_ras_commit_stack;
   localparam int K_LINE = 0, K_PTR = 1, K_RELOAD = 2, K_EMPTY = 3, K_FULL = 4;

   typedef struct {
      string       name;
      int          kind;
      int          idx;
      logic [38:0] exp;
   } exp_t;

   logic Clk;
   logic Rest;
   int   n_cmp;
   int   n_bad;
   exp_t sb[$];
   logic [38:0] mq[$];
   logic [38:0] lines [1:15];

   ras_commit_stack_if #(.STACKPTRW(4), .STACKWIDE(32), .RECURCOUNT(7)) bus ();

   ras_commit_stack #(.STACKDEEP(16), .STACKPTRW(4), .STACKWIDE(32), .RECURCOUNT(7)) dut (
      .Clk  (Clk),
      .Rest (Rest),
      .bus  (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   assign lines[1]  = bus.RELOADLINE1;
   assign lines[2]  = bus.RELOADLINE2;
   assign lines[3]  = bus.RELOADLINE3;
   assign lines[4]  = bus.RELOADLINE4;
   assign lines[5]  = bus.RELOADLINE5;
   assign lines[6]  = bus.RELOADLINE6;
   assign lines[7]  = bus.RELOADLINE7;
   assign lines[8]  = bus.RELOADLINE8;
   assign lines[9]  = bus.RELOADLINE9;
   assign lines[10] = bus.RELOADLINE10;
   assign lines[11] = bus.RELOADLINE11;
   assign lines[12] = bus.RELOADLINE12;
   assign lines[13] = bus.RELOADLINE13;
   assign lines[14] = bus.RELOADLINE14;
   assign lines[15] = bus.RELOADLINE15;

   function automatic logic [38:0] ent(int c, logic [31:0] a);
      logic [6:0] c7;
      c7 = c[6:0];
      return {c7, a};
   endfunction

   function automatic logic [38:0] obs(int kind, int idx);
      case (kind)
         K_LINE:   return lines[idx];
         K_PTR:    return {35'd0, bus.RELOADPTR};
         K_RELOAD: return {38'd0, bus.RELOAD};
         K_EMPTY:  return {38'd0, bus.STACKEMPTY};
         default:  return {38'd0, bus.STACKFULL};
      endcase
   endfunction

   function automatic void want(string name, int kind, int idx, logic [38:0] v);
      exp_t x;
      x.name = name; x.kind = kind; x.idx = idx; x.exp = v;
      sb.push_back(x);
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      bus.CommitCall = 1'b0; bus.CommitRet = 1'b0; bus.Flush = 1'b0; bus.CommitAddr = '0;
      Rest = 1'b1;
      #2;
      Rest = 1'b0;
   endtask

   task automatic push(logic [31:0] a);
      bus.CommitCall = 1'b1; bus.CommitAddr = a;
      step();
      bus.CommitCall = 1'b0;
   endtask

   task automatic pop();
      bus.CommitRet = 1'b1;
      step();
      bus.CommitRet = 1'b0;
   endtask

   task automatic test_reset();
      exp_t x;
      do_reset();
      push(32'h55);
      push(32'h66);
      Rest = 1'b1;
      #1;
      want("rst_ptr", K_PTR, 0, 0);
      want("rst_empty", K_EMPTY, 0, 1);
      want("rst_full", K_FULL, 0, 0);
      want("rst_reload", K_RELOAD, 0, 0);
      want("rst_line1", K_LINE, 1, 0);
      want("rst_line2", K_LINE, 2, 0);
      while (sb.size() > 0) begin
         x = sb.pop_front(); n_cmp++;
         if (obs(x.kind, x.idx) !== x.exp) begin
            n_bad++; $display("FAIL %s: got %h want %h", x.name, obs(x.kind, x.idx), x.exp);
         end
      end
      Rest = 1'b0;
   endtask

   task automatic test_basic_flush();
      exp_t x;
      do_reset();
      push(32'h1C000100);
      push(32'h1C000200);
      push(32'h1C000300);
      bus.Flush = 1'b1;
      want("bf_reload", K_RELOAD, 0, 1);
      want("bf_ptr", K_PTR, 0, 3);
      want("bf_line1", K_LINE, 1, ent(1, 32'h1C000100));
      want("bf_line2", K_LINE, 2, ent(1, 32'h1C000200));
      want("bf_line3", K_LINE, 3, ent(1, 32'h1C000300));
      want("bf_line4", K_LINE, 4, 0);
      step();
      bus.Flush = 1'b0;
      while (sb.size() > 0) begin
         x = sb.pop_front(); n_cmp++;
         if (obs(x.kind, x.idx) !== x.exp) begin
            n_bad++; $display("FAIL %s: got %h want %h", x.name, obs(x.kind, x.idx), x.exp);
         end
      end
      want("bf_reload_drop", K_RELOAD, 0, 0);
      step();
      while (sb.size() > 0) begin
         x = sb.pop_front(); n_cmp++;
         if (obs(x.kind, x.idx) !== x.exp) begin
            n_bad++; $display("FAIL %s: got %h want %h", x.name, obs(x.kind, x.idx), x.exp);
         end
      end
   endtask

   task automatic test_recursion();
      exp_t x;
      do_reset();
      for (int i = 0; i < 5; i++) push(32'h1C000400);
      pop(); pop();
      want("rc_ptr1", K_PTR, 0, 1);
      want("rc_line1", K_LINE, 1, ent(3, 32'h1C000400));
      want("rc_line2", K_LINE, 2, 0);
      while (sb.size() > 0) begin
         x = sb.pop_front(); n_cmp++;
         if (obs(x.kind, x.idx) !== x.exp) begin
            n_bad++; $display("FAIL %s: got %h want %h", x.name, obs(x.kind, x.idx), x.exp);
         end
      end
      pop(); pop(); pop();
      want("rc_ptr0", K_PTR, 0, 0);
      want("rc_line1_zero", K_LINE, 1, 0);
      want("rc_empty", K_EMPTY, 0, 1);
      while (sb.size() > 0) begin
         x = sb.pop_front(); n_cmp++;
         if (obs(x.kind, x.idx) !== x.exp) begin
            n_bad++; $display("FAIL %s: got %h want %h", x.name, obs(x.kind, x.idx), x.exp);
         end
      end
      pop();
      want("rc_underflow_ptr", K_PTR, 0, 0);
      want("rc_underflow_line1", K_LINE, 1, 0);
      while (sb.size() > 0) begin
         x = sb.pop_front(); n_cmp++;
         if (obs(x.kind, x.idx) !== x.exp) begin
            n_bad++; $display("FAIL %s: got %h want %h", x.name, obs(x.kind, x.idx), x.exp);
         end
      end
   endtask

   task automatic test_overflow();
      exp_t x;
      do_reset();
      for (int i = 0; i < 16; i++) push(32'h100 + i);
      want("ov_full", K_FULL, 0, 1);
      want("ov_empty", K_EMPTY, 0, 0);
      want("ov_ptr", K_PTR, 0, 15);
      want("ov_line1", K_LINE, 1, ent(1, 32'h101));
      want("ov_line8", K_LINE, 8, ent(1, 32'h108));
      want("ov_line15", K_LINE, 15, ent(1, 32'h10F));
      while (sb.size() > 0) begin
         x = sb.pop_front(); n_cmp++;
         if (obs(x.kind, x.idx) !== x.exp) begin
            n_bad++; $display("FAIL %s: got %h want %h", x.name, obs(x.kind, x.idx), x.exp);
         end
      end
   endtask

   task automatic test_saturation();
      exp_t x;
      do_reset();
      for (int i = 0; i < 128; i++) push(32'hABC0);
      want("sat_line1", K_LINE, 1, ent(127, 32'hABC0));
      want("sat_line2", K_LINE, 2, ent(1, 32'hABC0));
      want("sat_ptr", K_PTR, 0, 2);
      while (sb.size() > 0) begin
         x = sb.pop_front(); n_cmp++;
         if (obs(x.kind, x.idx) !== x.exp) begin
            n_bad++; $display("FAIL %s: got %h want %h", x.name, obs(x.kind, x.idx), x.exp);
         end
      end
   endtask

   task automatic test_simultaneous();
      exp_t x;
      do_reset();
      push(32'hA);
      bus.CommitRet = 1'b1; bus.CommitCall = 1'b1; bus.CommitAddr = 32'hB; bus.Flush = 1'b1;
      want("sim_reload", K_RELOAD, 0, 1);
      want("sim_ptr", K_PTR, 0, 1);
      want("sim_line1", K_LINE, 1, ent(1, 32'hB));
      want("sim_line2", K_LINE, 2, 0);
      step();
      bus.CommitRet = 1'b0; bus.CommitCall = 1'b0; bus.Flush = 1'b0;
      while (sb.size() > 0) begin
         x = sb.pop_front(); n_cmp++;
         if (obs(x.kind, x.idx) !== x.exp) begin
            n_bad++; $display("FAIL %s: got %h want %h", x.name, obs(x.kind, x.idx), x.exp);
         end
      end
   endtask

   task automatic test_flush_hold();
      int highs;
      do_reset();
      push(32'h77);
      highs = 0;
      bus.Flush = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         if (i == 2) bus.Flush = 1'b0;
         if (bus.RELOAD === 1'b1) highs++;
      end
      n_cmp++;
      if (highs !== 3) begin
         n_bad++; $display("FAIL fh_strobe_count: got %0d want 3", highs);
      end
   endtask

   task automatic test_flush_reset();
      exp_t x;
      do_reset();
      push(32'h88);
      push(32'h99);
      bus.Flush = 1'b1;
      step();
      want("fr_first_strobe", K_RELOAD, 0, 1);
      while (sb.size() > 0) begin
         x = sb.pop_front(); n_cmp++;
         if (obs(x.kind, x.idx) !== x.exp) begin
            n_bad++; $display("FAIL %s: got %h want %h", x.name, obs(x.kind, x.idx), x.exp);
         end
      end
      step();
      #2;
      Rest = 1'b1;
      #1;
      want("fr_reload_drop", K_RELOAD, 0, 0);
      want("fr_ptr", K_PTR, 0, 0);
      want("fr_line1", K_LINE, 1, 0);
      want("fr_line2", K_LINE, 2, 0);
      want("fr_empty", K_EMPTY, 0, 1);
      while (sb.size() > 0) begin
         x = sb.pop_front(); n_cmp++;
         if (obs(x.kind, x.idx) !== x.exp) begin
            n_bad++; $display("FAIL %s: got %h want %h", x.name, obs(x.kind, x.idx), x.exp);
         end
      end
      bus.Flush = 1'b0;
      #1;
      Rest = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         want("fr_no_strobe", K_RELOAD, 0, 0);
         while (sb.size() > 0) begin
            x = sb.pop_front(); n_cmp++;
            if (obs(x.kind, x.idx) !== x.exp) begin
               n_bad++; $display("FAIL %s: got %h want %h", x.name, obs(x.kind, x.idx), x.exp);
            end
         end
      end
   endtask

   // Reference model keeps the committed stack as a queue, oldest entry at index 0.
   task automatic test_random();
      exp_t        x;
      bit          c, r, f;
      logic [31:0] a;
      logic [38:0] t;
      do_reset();
      mq.delete();
      for (int cyc = 0; cyc < 400; cyc++) begin
         c = ($urandom_range(0, 99) < 60);
         r = ($urandom_range(0, 99) < 35);
         f = ($urandom_range(0, 99) < 10);
         a = 32'h40 + 32'($urandom_range(0, 2)) * 4;
         if (r && mq.size() > 0) begin
            t = mq[mq.size()-1];
            if (t[38:32] > 7'd1) mq[mq.size()-1] = {t[38:32] - 7'd1, t[31:0]};
            else void'(mq.pop_back());
         end
         if (c) begin
            if (mq.size() > 0 && mq[mq.size()-1][31:0] == a && mq[mq.size()-1][38:32] != 7'd127) begin
               t = mq[mq.size()-1];
               mq[mq.size()-1] = {t[38:32] + 7'd1, a};
            end else begin
               if (mq.size() == 15) void'(mq.pop_front());
               mq.push_back(ent(1, a));
            end
         end
         want("rnd_ptr", K_PTR, 0, 39'(mq.size()));
         want("rnd_reload", K_RELOAD, 0, {38'd0, f});
         for (int n = 1; n <= 15; n++) want("rnd_line", K_LINE, n, (n <= mq.size()) ? mq[n-1] : 39'd0);
         bus.CommitCall = c; bus.CommitRet = r; bus.Flush = f; bus.CommitAddr = a;
         step();
         while (sb.size() > 0) begin
            x = sb.pop_front(); n_cmp++;
            if (obs(x.kind, x.idx) !== x.exp) begin
               n_bad++;
               $display("FAIL %s[%0d] cyc %0d: got %h want %h", x.name, x.idx, cyc, obs(x.kind, x.idx), x.exp);
            end
         end
      end
      bus.CommitCall = 1'b0; bus.CommitRet = 1'b0; bus.Flush = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      Rest = 1'b1;
      bus.CommitCall = 1'b0; bus.CommitRet = 1'b0; bus.Flush = 1'b0; bus.CommitAddr = '0;
      #12;
      Rest = 1'b0;
      step();
      test_reset();
      test_basic_flush();
      test_recursion();
      test_overflow();
      test_saturation();
      test_simultaneous();
      test_flush_hold();
      test_flush_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ras_commit_stack.md
# ras_commit_stack

Architectural (commit-side) return-address stack. It tracks call/return instructions as they retire and holds the non-speculative RAS image. On a pipeline flush it drives the reload interface of the speculative front-end RAS with that image, so the predictor restarts from committed state. It sits in the commit stage and feeds the fetch-stage stack's reload port directly.

## Interface
- STACKDEEP, 16: storage entries; only STACKDEEP-1 are usable, because the reload bus carries 15 lines.
- STACKPTRW, 4: pointer width.
- STACKWIDE, 32: return-address width.
- RECURCOUNT, 7: recursion-counter width per entry.

Ports:
- Clk  in  1  system clock, single clock domain.
- Rest  in  1  asynchronous, active-high reset.
- CommitCall  in  1  a retiring instruction is a call; push CommitAddr.
- CommitAddr  in  STACKWIDE  return address of the retiring call.
- CommitRet  in  1  a retiring instruction is a return; pop.
- Flush  in  1  pipeline flush request from commit.
- RELOAD  out  1  one-cycle-per-request reload strobe to the speculative RAS.
- RELOADPTR  out  STACKPTRW  committed stack pointer (number of valid entries).
- RELOADLINE1..RELOADLINE15  out  STACKWIDE+RECURCOUNT each  committed entries 0..14. Packing: {count, addr}.
- STACKEMPTY  out  1  high when the pointer equals 0.
- STACKFULL  out  1  high when the pointer equals 15.

## Operation
- State:
  - ptr (0..15);
  - entries E[0..14], each {cnt[RECURCOUNT-1:0], addr[STACKWIDE-1:0]};
  - RELOAD register.
  - Top entry = E[ptr-1].
- Push (CommitCall):
  - If ptr>0, E[ptr-1].addr==CommitAddr and E[ptr-1].cnt < 2^RECURCOUNT-1: increment that cnt; ptr unchanged.
  - Else if ptr<15: E[ptr]={1, CommitAddr}; ptr+1.
  - Else (full): shift E[i]<=E[i+1] for i=0..13, discarding the oldest entry; E[14]={1, CommitAddr}; ptr stays 15.
- Pop (CommitRet):
  - If ptr==0: no effect, no wrap.
  - Else if E[ptr-1].cnt>1: decrement it.
  - Else: E[ptr-1]<=0; ptr-1.
- CommitCall and CommitRet in the same cycle: the pop is evaluated first, then the push is applied to the post-pop state. Both take effect in one cycle.
- Counter arithmetic:
  - cnt never wraps; saturation is handled by the new-entry rule above.
  - cnt is never 0 for a valid entry.
  - Invalid entries (index ≥ ptr) are held at all-zero.
- Flush: RELOAD is registered as RELOAD <= Flush. A Flush held for k cycles produces k strobe cycles.
- RELOADLINEn is wired continuously to E[n-1]; RELOADPTR is wired to ptr. Both are register outputs, with no combinational path from inputs.
- Commit inputs arriving in the Flush cycle are younger-than-flush-safe (they retire before the flush point). They are applied, and the resulting image is what appears during the RELOAD cycle.

## Timing
- Reset (asynchronous, immediate): ptr=0, all E=0, RELOAD=0, STACKEMPTY=1, STACKFULL=0, all RELOADLINEn=0, RELOADPTR=0.
- Push/pop latency: 1 cycle. The update is visible on RELOADLINE/RELOADPTR at the next edge.
- Flush latency: Flush sampled at edge N gives RELOAD=1 during cycle N+1. The image shown is the state after edge N, which includes any commit sampled at edge N.
- Commits sampled during the RELOAD cycle update state at the following edge. The image is only guaranteed during RELOAD=1; the consumer samples it at that edge.
- Reset asserted mid-flush: RELOAD drops immediately and no strobe is produced after release.

## Test plan
- Reset, then CommitCall with 0x1C000100, 0x1C000200, 0x1C000300 on consecutive cycles, then Flush -> next cycle RELOAD=1, RELOADPTR=3, LINE1={1,0x1C000100}, LINE3={1,0x1C000300}, LINE4=0.
- Recursion: 5 pushes of 0x1C000400 then 2 CommitRet -> RELOADPTR=1, LINE1 cnt=3. Continuing to 3 more CommitRet -> ptr=0, LINE1=0, STACKEMPTY=1. A further CommitRet leaves ptr at 0.
- Overflow: 16 distinct pushes 0x100..0x10F -> STACKFULL=1, ptr=15, LINE1=0x101 (0x100 dropped), LINE15=0x10F.
- Saturation: 128 pushes of 0xABC0 -> LINE1 cnt=127, LINE2={1,0xABC0}, ptr=2.
- Simultaneous: stack [0xA(cnt1)], then CommitRet+CommitCall(0xB) in the same cycle, with Flush in the same cycle -> RELOAD next cycle shows ptr=1, LINE1={1,0xB}.
- Flush held 3 cycles -> RELOAD high exactly 3 cycles. Rest pulsed during the second cycle -> RELOAD=0 immediately, with all lines and ptr zero.
